uc_arbiter: RTL and testbench

Unit-clause arbiter and sequencer for the global state table (gst). Collects implied literals from `NUM_ENGINE` BCP engines by round-robin arbitration, buffers them in a FIFO and optionally filters duplicates and detects conflicts against queued entries. It also injects the initial decision literal and drives the gst write interface one literal per pop. It sits between the BCP engines and gst, and reports propagation completion and conflicts to the top-level solver control.

---
 rtl/uc_arbiter_pkg.sv | 28 ++
 rtl/uc_arbiter_if.sv | 39 +++
 rtl/uc_arbiter_fifo.sv | 66 ++++++
 rtl/uc_arbiter.sv | 174 +++++++++++++++++
 tb/tb_uc_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uc_arbiter_pkg.sv
// Shared types and sizing for the unit-clause arbiter.
// Literals are LW-bit two's complement values; zero is the null literal.
package uc_arbiter_pkg;

   localparam int NUM_ENGINE  = 4;
   localparam int LIT_IDX_MAX = 64;
   localparam int FIFO_DEPTH  = 8;

   localparam int LW    = $clog2(LIT_IDX_MAX) + 1;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int RR_W  = (NUM_ENGINE > 1) ? $clog2(NUM_ENGINE) : 1;

   typedef logic [LW-1:0] lit_t;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_DECIDE    = 2'd1,
      ST_PROPAGATE = 2'd2,
      ST_CONFLICT  = 2'd3
   } ucarb_state_t;

   // Opposite-polarity literal of the same variable
   function automatic lit_t lit_neg(input lit_t l);
      return ~l + 1'b1;
   endfunction

endpackage

// File: rtl/uc_arbiter_if.sv
// Handshake bundle between BCP engines, decision source, gst and the arbiter.
// master = environment side, slave = arbiter side.
interface uc_arbiter_if;
   import uc_arbiter_pkg::*;

   logic [NUM_ENGINE-1:0][LW-1:0] bcp2ucarb_lit;
   logic [NUM_ENGINE-1:0]         bcp2ucarb_valid;
   logic [NUM_ENGINE-1:0]         ucarb2bcp_ready;
   logic [NUM_ENGINE-1:0]         bcp2ucarb_idle;
   lit_t                          dec2ucarb_lit;
   logic                          dec2ucarb_valid;
   logic                          ucarb2dec_ready;
   lit_t                          ucarb2gst_lit;
   logic                          ucarb2gst_valid;
   lit_t                          ucarb2gst_init_lit;
   logic                          ucarb2gst_init_valid;
   logic                          gst2ucarb_pop;
   logic                          flush;
   logic                          ucarb_done;
   logic                          ucarb_conflict;
   lit_t                          ucarb_conflict_lit;

   modport master (
      output bcp2ucarb_lit, bcp2ucarb_valid, bcp2ucarb_idle,
             dec2ucarb_lit, dec2ucarb_valid, gst2ucarb_pop, flush,
      input  ucarb2bcp_ready, ucarb2dec_ready, ucarb2gst_lit, ucarb2gst_valid,
             ucarb2gst_init_lit, ucarb2gst_init_valid,
             ucarb_done, ucarb_conflict, ucarb_conflict_lit
   );

   modport slave (
      input  bcp2ucarb_lit, bcp2ucarb_valid, bcp2ucarb_idle,
             dec2ucarb_lit, dec2ucarb_valid, gst2ucarb_pop, flush,
      output ucarb2bcp_ready, ucarb2dec_ready, ucarb2gst_lit, ucarb2gst_valid,
             ucarb2gst_init_lit, ucarb2gst_init_valid,
             ucarb_done, ucarb_conflict, ucarb_conflict_lit
   );

endinterface

// File: rtl/uc_arbiter_fifo.sv
// Unit-clause FIFO: storage, wrapping pointers and occupancy count.
// Every slot is exposed with a valid bit so the arbiter can search the queue.
module uc_fifo
   import uc_arbiter_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  push,
   input  logic                  pop,
   input  lit_t                  din,
   output lit_t                  head,
   output logic                  full,
   output logic                  empty,
   output lit_t                  entries [FIFO_DEPTH],
   output logic [FIFO_DEPTH-1:0] entry_valid
);

   lit_t             mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(FIFO_DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];
   assign entries = mem;

   // Pointer, count and storage update; clear wins over push/pop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (!do_push && do_pop) count <= count - 1'b1;
      end
   end

   // A slot is live when its distance from the read pointer is below the count
   always_comb begin
      logic [PTR_W-1:0] offset;
      offset      = '0;
      entry_valid = '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         offset         = PTR_W'(i) - rd_ptr;
         entry_valid[i] = (CNT_W'(offset) < count);
      end
   end

endmodule

// File: rtl/uc_arbiter.sv
// Unit-clause arbiter: round-robin collection of implied literals from the
// BCP engines, decision injection and one-literal-per-pop feed to gst.
// Optional build macro UCARB_DEDUP_EN: drop duplicates of queued literals and
// raise a conflict when the opposite literal is already queued.
//
// state        | meaning
// ST_IDLE      | waiting for a decision literal
// ST_DECIDE    | decision presented to gst on init_lit/init_valid
// ST_PROPAGATE | arbitrating engines, FIFO head presented to gst
// ST_CONFLICT  | opposite literals seen; frozen until flush
module uc_arbiter
   import uc_arbiter_pkg::*;
(
   input logic         clk,
   input logic         rst_n,
   uc_arbiter_if.slave bus
);

   ucarb_state_t    state_q;
   ucarb_state_t    state_d;
   logic [RR_W-1:0] rr_ptr_q;
   logic [RR_W-1:0] rr_next;
   lit_t            init_lit_q;
   lit_t            conflict_lit_q;

   logic            gnt_found;
   logic [RR_W-1:0] gnt_idx;
   lit_t            in_lit;
   logic            arb_open;
   logic            accept;
   logic            in_null;
   logic            hit_same;
   logic            hit_neg;
   logic            push;
   logic            pop;
   logic            conflict_hit;
   logic            gst_valid;
   logic            dec_ready;
   logic            dec_hs;
   logic            done;

   lit_t                  fifo_head;
   logic                  fifo_full;
   logic                  fifo_empty;
   lit_t                  fifo_entries [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] fifo_entry_valid;

   uc_fifo u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr         (bus.flush),
      .push        (push),
      .pop         (pop),
      .din         (in_lit),
      .head        (fifo_head),
      .full        (fifo_full),
      .empty       (fifo_empty),
      .entries     (fifo_entries),
      .entry_valid (fifo_entry_valid)
   );

   // Round-robin search: first valid engine at or after rr_ptr, wrapping
   always_comb begin
      int j;
      j         = 0;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int k = 0; k < NUM_ENGINE; k++) begin
         j = (int'(rr_ptr_q) + k) % NUM_ENGINE;
         if (!gnt_found && bus.bcp2ucarb_valid[j]) begin
            gnt_found = 1'b1;
            gnt_idx   = RR_W'(j);
         end
      end
   end

   assign in_lit   = bus.bcp2ucarb_lit[gnt_idx];
   assign in_null  = (in_lit == '0);
   assign rr_next  = (gnt_idx == RR_W'(NUM_ENGINE - 1)) ? '0 : gnt_idx + 1'b1;

   // Registered count gates the grant, so a same-cycle pop never frees a slot
   assign arb_open = (state_q == ST_PROPAGATE) && !bus.flush && !fifo_full;
   assign accept   = arb_open && gnt_found;

`ifdef UCARB_DEDUP_EN
   // Search the live queue for the same or the opposite literal
   always_comb begin
      hit_same = 1'b0;
      hit_neg  = 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (fifo_entry_valid[i] && (fifo_entries[i] == in_lit))          hit_same = 1'b1;
         if (fifo_entry_valid[i] && (fifo_entries[i] == lit_neg(in_lit))) hit_neg  = 1'b1;
      end
   end
`else
   logic unused_fifo_view;

   assign hit_same = 1'b0;
   assign hit_neg  = 1'b0;

   // Queue contents are only needed by the dedup search
   always_comb begin
      unused_fifo_view = ^fifo_entry_valid;
      for (int i = 0; i < FIFO_DEPTH; i++) unused_fifo_view = unused_fifo_view ^ (^fifo_entries[i]);
   end
`endif

   assign push         = accept && !in_null && !hit_same && !hit_neg;
   assign conflict_hit = accept && !in_null && hit_neg;
   assign gst_valid    = (state_q == ST_PROPAGATE) && !fifo_empty;
   assign pop          = bus.gst2ucarb_pop && gst_valid;
   assign dec_hs       = dec_ready && bus.dec2ucarb_valid;

   // Next-state and handshake outputs; flush overrides everything
   always_comb begin
      state_d   = state_q;
      dec_ready = 1'b0;
      done      = 1'b0;
      if (bus.flush) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               dec_ready = rst_n;
               if (bus.dec2ucarb_valid) state_d = ST_DECIDE;
            end
            ST_DECIDE: begin
               if (bus.gst2ucarb_pop) state_d = ST_PROPAGATE;
            end
            ST_PROPAGATE: begin
               if (conflict_hit) begin
                  state_d = ST_CONFLICT;
               end else if (fifo_empty && (bus.bcp2ucarb_valid == '0) && (&bus.bcp2ucarb_idle)) begin
                  done    = 1'b1;
                  state_d = ST_IDLE;
               end
            end
            ST_CONFLICT: state_d = ST_CONFLICT;
            default:     state_d = ST_IDLE;
         endcase
      end
   end

   // State, round-robin pointer and latched literals
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         rr_ptr_q       <= '0;
         init_lit_q     <= '0;
         conflict_lit_q <= '0;
      end else begin
         state_q <= state_d;
         if (bus.flush) begin
            rr_ptr_q       <= '0;
            conflict_lit_q <= '0;
         end else begin
            if (accept)       rr_ptr_q       <= rr_next;
            if (conflict_hit) conflict_lit_q <= in_lit;
         end
         if (dec_hs) init_lit_q <= bus.dec2ucarb_lit;
      end
   end

   assign bus.ucarb2bcp_ready      = accept ? (NUM_ENGINE'(1) << gnt_idx) : '0;
   assign bus.ucarb2dec_ready      = dec_ready;
   assign bus.ucarb2gst_valid      = gst_valid;
   assign bus.ucarb2gst_lit        = gst_valid ? fifo_head : '0;
   assign bus.ucarb2gst_init_valid = (state_q == ST_DECIDE);
   assign bus.ucarb2gst_init_lit   = (state_q == ST_DECIDE) ? init_lit_q : '0;
   assign bus.ucarb_done           = done;
   assign bus.ucarb_conflict       = (state_q == ST_CONFLICT);
   assign bus.ucarb_conflict_lit   = conflict_lit_q;

endmodule

// File: tb/tb_uc_arbiter.sv
// Bench for uc_arbiter: a queue-based reference model checked on every
// falling edge, directed scenarios with literal expectations, then random traffic.
module tb_uc_arbiter;
   import uc_arbiter_pkg::*;

   logic clk = 1'b0;
   logic rst_n;

   uc_arbiter_if bus ();

   uc_arbiter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   localparam int M_IDLE = 0;
   localparam int M_DEC  = 1;
   localparam int M_PROP = 2;
   localparam int M_CONF = 3;

   lit_t m_q[$];
   int   m_mode = M_IDLE;
   int   m_rr   = 0;
   lit_t m_dlit = '0;
   lit_t m_clit = '0;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic lit_t L(input int v);
      return lit_t'(v);
   endfunction

   function automatic int sval(input lit_t l);
      return (int'(l) >= (1 << (LW - 1))) ? int'(l) - (1 << LW) : int'(l);
   endfunction

   // Reference model: compare outputs mid-cycle, then advance by the cycle's inputs
   always @(negedge clk) begin : model_cmp
      int                    g;
      int                    e_rdy;
      int                    e_gv;
      int                    e_gl;
      int                    e_done;
      lit_t                  l;
      lit_t                  nl;
      bit                    same;
      bit                    neg;
      if (!rst_n) begin
         m_q.delete();
         m_mode = M_IDLE;
         m_rr   = 0;
         m_dlit = '0;
         m_clit = '0;
         chk("rst_ready",        int'(bus.ucarb2bcp_ready), 0);
         chk("rst_dec_ready",    int'(bus.ucarb2dec_ready), 0);
         chk("rst_gst_valid",    int'(bus.ucarb2gst_valid), 0);
         chk("rst_gst_lit",      int'(bus.ucarb2gst_lit), 0);
         chk("rst_init_valid",   int'(bus.ucarb2gst_init_valid), 0);
         chk("rst_init_lit",     int'(bus.ucarb2gst_init_lit), 0);
         chk("rst_done",         int'(bus.ucarb_done), 0);
         chk("rst_conflict",     int'(bus.ucarb_conflict), 0);
         chk("rst_conflict_lit", int'(bus.ucarb_conflict_lit), 0);
      end else begin
         g = -1;
         if (m_mode == M_PROP && !bus.flush && m_q.size() < FIFO_DEPTH) begin
            for (int k = 0; k < NUM_ENGINE; k++)
               if (g < 0 && bus.bcp2ucarb_valid[(m_rr + k) % NUM_ENGINE]) g = (m_rr + k) % NUM_ENGINE;
         end
         e_rdy  = (g >= 0) ? (1 << g) : 0;
         e_gv   = (m_mode == M_PROP && m_q.size() > 0) ? 1 : 0;
         e_gl   = (e_gv != 0) ? int'(m_q[0]) : 0;
         e_done = (m_mode == M_PROP && !bus.flush && m_q.size() == 0 &&
                   bus.bcp2ucarb_valid == '0 && bus.bcp2ucarb_idle == '1) ? 1 : 0;

         chk("ready",        int'(bus.ucarb2bcp_ready), e_rdy);
         chk("dec_ready",    int'(bus.ucarb2dec_ready), (m_mode == M_IDLE && !bus.flush) ? 1 : 0);
         chk("gst_valid",    int'(bus.ucarb2gst_valid), e_gv);
         chk("gst_lit",      int'(bus.ucarb2gst_lit), e_gl);
         chk("init_valid",   int'(bus.ucarb2gst_init_valid), (m_mode == M_DEC) ? 1 : 0);
         chk("init_lit",     int'(bus.ucarb2gst_init_lit), (m_mode == M_DEC) ? int'(m_dlit) : 0);
         chk("done",         int'(bus.ucarb_done), e_done);
         chk("conflict",     int'(bus.ucarb_conflict), (m_mode == M_CONF) ? 1 : 0);
         chk("conflict_lit", int'(bus.ucarb_conflict_lit), int'(m_clit));

         if (bus.flush) begin
            m_mode = M_IDLE;
            m_q.delete();
            m_rr   = 0;
            m_clit = '0;
         end else begin
            case (m_mode)
               M_IDLE: if (bus.dec2ucarb_valid) begin
                  m_dlit = bus.dec2ucarb_lit;
                  m_mode = M_DEC;
               end
               M_DEC: if (bus.gst2ucarb_pop) m_mode = M_PROP;
               M_PROP: begin
                  same = 1'b0;
                  neg  = 1'b0;
                  l    = '0;
                  if (g >= 0) begin
                     l    = bus.bcp2ucarb_lit[g];
                     m_rr = (g + 1) % NUM_ENGINE;
                     nl   = lit_t'(-sval(l));
`ifdef UCARB_DEDUP_EN
                     foreach (m_q[i]) begin
                        if (m_q[i] == l)  same = 1'b1;
                        if (m_q[i] == nl) neg  = 1'b1;
                     end
`endif
                  end
                  if (bus.gst2ucarb_pop && m_q.size() > 0) void'(m_q.pop_front());
                  if (g >= 0 && l != '0 && !same && !neg) m_q.push_back(l);
                  if (g >= 0 && l != '0 && neg) begin
                     m_mode = M_CONF;
                     m_clit = l;
                  end else if (e_done != 0) begin
                     m_mode = M_IDLE;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lit(input int e, input int v);
      bus.bcp2ucarb_lit[e] = L(v);
   endtask

   initial begin
      rst_n               = 1'b0;
      bus.bcp2ucarb_lit   = '0;
      bus.bcp2ucarb_valid = '0;
      bus.bcp2ucarb_idle  = '0;
      bus.dec2ucarb_lit   = '0;
      bus.dec2ucarb_valid = 1'b0;
      bus.gst2ucarb_pop   = 1'b0;
      bus.flush           = 1'b0;

      nxt();
      #1;
      chk("reset_gst_valid", int'(bus.ucarb2gst_valid), 0);
      chk("reset_dec_ready", int'(bus.ucarb2dec_ready), 0);
      nxt();
      rst_n = 1'b1;

      // Decision handshake
      nxt();
      bus.dec2ucarb_lit   = L(5);
      bus.dec2ucarb_valid = 1'b1;
      #1;
      chk("dec_accept_ready", int'(bus.ucarb2dec_ready), 1);
      nxt();
      bus.dec2ucarb_valid = 1'b0;
      bus.gst2ucarb_pop   = 1'b1;
      #1;
      chk("dec_init_valid", int'(bus.ucarb2gst_init_valid), 1);
      chk("dec_init_lit",   int'(bus.ucarb2gst_init_lit), 5);
      chk("dec_gst_valid",  int'(bus.ucarb2gst_valid), 0);

      // Round-robin between engines 0 and 2
      nxt();
      bus.gst2ucarb_pop   = 1'b0;
      set_lit(0, 3);
      set_lit(2, -4);
      bus.bcp2ucarb_valid = 4'b0101;
      #1;
      chk("prop_gst_empty", int'(bus.ucarb2gst_valid), 0);
      chk("rr_first",       int'(bus.ucarb2bcp_ready), 1);
      nxt();
      #1;
      chk("rr_second",      int'(bus.ucarb2bcp_ready), 4);
      chk("rr_head_3",      int'(bus.ucarb2gst_lit), 3);
      nxt();
      bus.bcp2ucarb_valid = '0;
      bus.gst2ucarb_pop   = 1'b1;
      #1;
      chk("rr_pop_3",       int'(bus.ucarb2gst_lit), 3);
      nxt();
      #1;
      chk("rr_pop_m4",      int'(bus.ucarb2gst_lit), int'(L(-4)));
      nxt();
      bus.gst2ucarb_pop   = 1'b0;
      #1;
      chk("rr_drained",     int'(bus.ucarb2gst_valid), 0);

      // Fill to full from engine 1
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         bus.bcp2ucarb_valid = 4'b0010;
         set_lit(1, 10 + i);
         #1;
         chk("fill_ready", int'(bus.ucarb2bcp_ready), 2);
         nxt();
      end
      set_lit(1, 18);
      #1;
      chk("full_ready",     int'(bus.ucarb2bcp_ready), 0);
      chk("full_gst_valid", int'(bus.ucarb2gst_valid), 1);
      nxt();
      bus.gst2ucarb_pop = 1'b1;
      #1;
      chk("full_pop_cycle_ready", int'(bus.ucarb2bcp_ready), 0);
      nxt();
      bus.gst2ucarb_pop = 1'b0;
      #1;
      chk("full_ready_back", int'(bus.ucarb2bcp_ready), 2);
      nxt();
      bus.bcp2ucarb_valid = '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         bus.gst2ucarb_pop = 1'b1;
         #1;
         chk("drain_order", int'(bus.ucarb2gst_lit), 11 + i);
         nxt();
      end
      bus.gst2ucarb_pop = 1'b0;
      #1;
      chk("drain_empty", int'(bus.ucarb2gst_valid), 0);

      // Duplicate and opposite literal from engine 3
      bus.bcp2ucarb_valid = 4'b1000;
      set_lit(3, 7);
      #1;
      chk("dup_first_ack", int'(bus.ucarb2bcp_ready), 8);
      nxt();
      #1;
      chk("dup_second_ack", int'(bus.ucarb2bcp_ready), 8);
      nxt();
      bus.bcp2ucarb_valid = '0;
      bus.gst2ucarb_pop   = 1'b1;
      #1;
      chk("dup_head", int'(bus.ucarb2gst_lit), 7);
      nxt();
      bus.gst2ucarb_pop = 1'b0;
      #1;
`ifdef UCARB_DEDUP_EN
      chk("dup_not_queued", int'(bus.ucarb2gst_valid), 0);
`else
      chk("dup_queued", int'(bus.ucarb2gst_valid), 1);
      bus.gst2ucarb_pop = 1'b1;
`endif
      nxt();
      bus.gst2ucarb_pop   = 1'b0;
      bus.bcp2ucarb_valid = 4'b1000;
      set_lit(3, 7);
      #1;
      chk("neg_setup_empty", int'(bus.ucarb2gst_valid), 0);
      nxt();
      set_lit(3, -7);
      #1;
      chk("neg_ack", int'(bus.ucarb2bcp_ready), 8);
      nxt();
      bus.bcp2ucarb_valid = '0;
      #1;
`ifdef UCARB_DEDUP_EN
      chk("conflict_set",    int'(bus.ucarb_conflict), 1);
      chk("conflict_lit",    int'(bus.ucarb_conflict_lit), int'(L(-7)));
      chk("conflict_gst_v",  int'(bus.ucarb2gst_valid), 0);
`else
      chk("no_conflict",     int'(bus.ucarb_conflict), 0);
      chk("neg_queued_head", int'(bus.ucarb2gst_lit), 7);
`endif
      bus.flush = 1'b1;
      nxt();
      bus.flush = 1'b0;
      #1;
      chk("flush_conflict", int'(bus.ucarb_conflict), 0);
      chk("flush_empty",    int'(bus.ucarb2gst_valid), 0);
      chk("flush_idle",     int'(bus.ucarb2dec_ready), 1);

      // Completion pulse
      bus.dec2ucarb_lit   = L(-9);
      bus.dec2ucarb_valid = 1'b1;
      nxt();
      bus.dec2ucarb_valid = 1'b0;
      bus.gst2ucarb_pop   = 1'b1;
      #1;
      chk("done_init_lit", int'(bus.ucarb2gst_init_lit), int'(L(-9)));
      nxt();
      bus.gst2ucarb_pop   = 1'b0;
      bus.bcp2ucarb_valid = 4'b0001;
      set_lit(0, 20);
      #1;
      chk("done_push_ack", int'(bus.ucarb2bcp_ready), 1);
      nxt();
      bus.bcp2ucarb_valid = '0;
      bus.gst2ucarb_pop   = 1'b1;
      #1;
      chk("done_head", int'(bus.ucarb2gst_lit), 20);
      chk("done_not_yet", int'(bus.ucarb_done), 0);
      nxt();
      bus.gst2ucarb_pop  = 1'b0;
      bus.bcp2ucarb_idle = '1;
      #1;
      chk("done_pulse", int'(bus.ucarb_done), 1);
      nxt();
      #1;
      chk("done_single", int'(bus.ucarb_done), 0);
      chk("done_to_idle", int'(bus.ucarb2dec_ready), 1);

      // Reset in the middle of propagation with three entries queued
      bus.bcp2ucarb_idle  = '0;
      bus.dec2ucarb_lit   = L(11);
      bus.dec2ucarb_valid = 1'b1;
      nxt();
      bus.dec2ucarb_valid = 1'b0;
      bus.gst2ucarb_pop   = 1'b1;
      nxt();
      bus.gst2ucarb_pop   = 1'b0;
      bus.bcp2ucarb_valid = 4'b0010;
      for (int i = 0; i < 3; i++) begin
         set_lit(1, 21 + i);
         nxt();
      end
      bus.bcp2ucarb_valid = '0;
      #1;
      chk("prereset_head", int'(bus.ucarb2gst_lit), 21);
      rst_n = 1'b0;
      #1;
      chk("midrst_gst_valid",  int'(bus.ucarb2gst_valid), 0);
      chk("midrst_gst_lit",    int'(bus.ucarb2gst_lit), 0);
      chk("midrst_dec_ready",  int'(bus.ucarb2dec_ready), 0);
      chk("midrst_init_valid", int'(bus.ucarb2gst_init_valid), 0);
      nxt();
      nxt();
      rst_n = 1'b1;
      #1;
      chk("postrst_idle",  int'(bus.ucarb2dec_ready), 1);
      chk("postrst_empty", int'(bus.ucarb2gst_valid), 0);

      // Random traffic against the model
      for (int c = 0; c < 3000; c++) begin
         nxt();
         for (int e = 0; e < NUM_ENGINE; e++) begin
            int mag;
            mag = int'($urandom_range(1, 10));
            bus.bcp2ucarb_valid[e] = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) == 0)     set_lit(e, 0);
            else if ($urandom_range(0, 1) == 0) set_lit(e, mag);
            else                                set_lit(e, -mag);
         end
         if ($urandom_range(0, 3) == 0) bus.bcp2ucarb_valid = '0;
         bus.bcp2ucarb_idle  = ($urandom_range(0, 2) == 0) ? '1 : NUM_ENGINE'($urandom);
         bus.gst2ucarb_pop   = ($urandom_range(0, 2) != 0);
         bus.dec2ucarb_valid = ($urandom_range(0, 1) == 0);
         bus.dec2ucarb_lit   = L(int'($urandom_range(1, 30)));
         bus.flush           = ($urandom_range(0, 47) == 0);
      end

      nxt();
      bus.bcp2ucarb_valid = '0;
      bus.dec2ucarb_valid = 1'b0;
      bus.gst2ucarb_pop   = 1'b0;
      bus.flush           = 1'b0;
      nxt();
      nxt();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
